// File: rtl/spi_master_ctrl.sv
// SPI master: shifts out one {cmd, payload} frame per accepted start and, for
// read-data commands, captures the slave's reply from MISO after a turnaround gap.
module spi_master_ctrl #(
  parameter int FRAME_W    = 10,
  parameter int DATA_W     = 8,
  parameter int TURNAROUND = 2,
  parameter int GAP        = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        cmd,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [1:0] CMD_RD_DATA = 2'b11;
  localparam logic [3:0] SHIFT_LAST  = 4'(FRAME_W - 1);
  localparam logic [3:0] WAIT_LAST   = 4'(TURNAROUND - 1);
  localparam logic [3:0] READ_LAST   = 4'(DATA_W - 1);
  localparam logic [3:0] STOP_LAST   = 4'(GAP - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEL   = 3'd1,
    SHIFT = 3'd2,
    WAIT  = 3'd3,
    READ  = 3'd4,
    STOP  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 rd_cmd_q, rd_cmd_d;
  logic [DATA_W-1:0]    rx_q, rx_d;
  logic [DATA_W-1:0]    rd_data_q, rd_data_d;
  logic                 done_q, done_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 ss_n_q, ss_n_d;
  logic                 mosi_q, mosi_d;
  logic                 accept;
  logic [3:0]           bit_idx;

  // The last STOP cycle also takes a start so a held start yields exactly GAP
  // deselected cycles between frames.
  assign accept = start && ((state_q == IDLE) ||
                            (state_q == STOP && cnt_q == STOP_LAST));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 4'd1;
    frame_d    = frame_q;
    rd_cmd_d   = rd_cmd_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    ss_n_d     = 1'b1;
    mosi_d     = 1'b0;
    bit_idx    = 4'd0;

    unique case (state_q)
      IDLE: begin
        cnt_d = 4'd0;
      end
      SEL: begin
        state_d = SHIFT;
        cnt_d   = 4'd0;
      end
      SHIFT: begin
        if (cnt_q == SHIFT_LAST) begin
          state_d = rd_cmd_q ? WAIT : STOP;
          cnt_d   = 4'd0;
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = READ;
          cnt_d   = 4'd0;
        end
      end
      READ: begin
        rx_d = {rx_q[DATA_W-2:0], MISO};
        if (cnt_q == READ_LAST) begin
          state_d = STOP;
          cnt_d   = 4'd0;
        end
      end
      STOP: begin
        if (cnt_q == STOP_LAST) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (accept) begin
      state_d  = SEL;
      cnt_d    = 4'd0;
      frame_d  = FRAME_W'({cmd, wr_data});
      rd_cmd_d = (cmd == CMD_RD_DATA);
      rx_d     = '0;
    end

    // Completion flags are raised on the edge that enters STOP, so they line up
    // with the first STOP cycle; rx_d already holds the final MISO bit here.
    if (state_d == STOP && state_q != STOP) begin
      done_d = 1'b1;
      if (rd_cmd_q) begin
        rd_valid_d = 1'b1;
        rd_data_d  = rx_d;
      end
    end

    // Pin values are computed from the next state so they are flop outputs.
    ss_n_d = (state_d == IDLE) || (state_d == STOP);
    unique case (state_d)
      SEL:     mosi_d = frame_d[FRAME_W-1];
      SHIFT: begin
        bit_idx = SHIFT_LAST - cnt_d;
        mosi_d  = frame_d[bit_idx];
      end
      default: mosi_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      frame_q    <= '0;
      rd_cmd_q   <= 1'b0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      rd_cmd_q   <= rd_cmd_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign SS_n     = ss_n_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: a behavioural SPI RAM slave on the pins plus an
// address/memory reference model driven from the issued commands.
module tb_spi_master_ctrl;
  localparam int TURN = 2;
  localparam int DW   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] wr_data = 8'h00;
  logic       MISO = 1'b0;
  logic       busy, done, rd_valid, SS_n, MOSI;
  logic [7:0] rd_data;

  int errs   = 0;
  int checks = 0;
  bit miso_stuck = 1'b0;

  // reference model
  logic [7:0] ref_mem [256] = '{default: 8'h00};
  logic [7:0] ref_addr = 8'h00;
  logic [7:0] ref_rd   = 8'h00;

  // slave model state
  logic [7:0]  s_mem [256] = '{default: 8'h00};
  logic [7:0]  s_addr  = 8'h00;
  logic [7:0]  s_reply = 8'h00;
  logic [10:0] s_bits  = '0;
  int          s_cnt   = 0;

  spi_master_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .cmd      (cmd),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave: counts selected cycles; bit 1 is the select bit, 2..11 the frame,
  // 12..13 turnaround, 14..21 its reply (driven ahead of the master's sample edge).
  always @(negedge clk) begin
    if (!rst_n || SS_n) begin
      s_cnt = 0;
      MISO  = miso_stuck;
    end else begin
      s_cnt++;
      if (s_cnt <= 11) s_bits = {s_bits[9:0], MOSI};
      if (s_cnt == 11) begin
        case (s_bits[9:8])
          2'b00, 2'b10: s_addr = s_bits[7:0];
          2'b01:        s_mem[s_addr] = s_bits[7:0];
          default:      s_reply = s_mem[s_addr];
        endcase
      end
      if (miso_stuck)                     MISO = 1'b1;
      else if (s_cnt >= 14 && s_cnt <= 21) MISO = s_reply[21 - s_cnt];
      else                                MISO = 1'b0;
    end
  end

  // One transaction, observed cycle by cycle; cycle 0 is the start edge.
  task automatic run_txn(input logic [1:0] c, input logic [7:0] d);
    int n, low, done_at, rv_at, dn;
    logic [10:0] seq;
    logic [7:0]  exp_rd, rd_at_done;
    bit ss_ok, busy_ok, idle_mosi_ok;
    n       = (c == 2'b11) ? 12 + TURN + DW : 12;
    exp_rd  = (c == 2'b11) ? (miso_stuck ? 8'hFF : ref_mem[ref_addr]) : ref_rd;
    seq = '0; low = 0; done_at = -1; rv_at = -1; dn = 0; rd_at_done = '0;
    ss_ok = 1'b1; busy_ok = 1'b1; idle_mosi_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; cmd = c; wr_data = d;
    for (int k = 1; k <= n + 1; k++) begin
      @(negedge clk);
      if (!SS_n) begin
        low++;
        if (low <= 11) seq = {seq[9:0], MOSI};
        else if (MOSI !== 1'b0) idle_mosi_ok = 1'b0;
      end else if (MOSI !== 1'b0) idle_mosi_ok = 1'b0;
      if (SS_n !== (k >= n)) ss_ok = 1'b0;
      if (busy !== (k <= n)) busy_ok = 1'b0;
      if (done === 1'b1) begin dn++; done_at = k; rd_at_done = rd_data; end
      if (rd_valid === 1'b1) rv_at = k;
      // random starts while busy must be ignored; none in the STOP cycle
      start   = (k < n) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd     = 2'($urandom);
      wr_data = 8'($urandom);
    end
    chk("mosi_seq",  32'(seq), 32'({c[1], c, d}));
    chk("ss_low",    low, n - 1);
    chk("ss_shape",  32'(ss_ok), 1);
    chk("busy",      32'(busy_ok), 1);
    chk("mosi_idle", 32'(idle_mosi_ok), 1);
    chk("done_at",   done_at, n);
    chk("done_cnt",  dn, 1);
    if (c == 2'b11) begin
      chk("rv_at",   rv_at, n);
      chk("rd_data", 32'(rd_at_done), 32'(exp_rd));
    end else begin
      chk("rv_none", rv_at, -1);
      chk("rd_hold", 32'(rd_data), 32'(exp_rd));
    end
    case (c)
      2'b00, 2'b10: ref_addr = d;
      2'b01:        ref_mem[ref_addr] = d;
      default:      ref_rd = exp_rd;
    endcase
  endtask

  initial begin
    int dcnt, bad, dones;
    logic [7:0] d5;

    // reset state
    @(negedge clk);
    chk("rst_ss_n", 32'(SS_n), 1);
    chk("rst_mosi", 32'(MOSI), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rv",   32'(rd_valid), 0);
    chk("rst_rd",   32'(rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // abort mid-SHIFT
    @(negedge clk);
    start = 1'b1; cmd = 2'b00; wr_data = 8'h5A;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_sel", 32'(SS_n), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_ss_n", 32'(SS_n), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_mosi", 32'(MOSI), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    bad  = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
      if (SS_n !== 1'b1) bad++;
    end
    chk("abort_nodone", dcnt, 0);
    chk("abort_ss_hi",  bad, 0);

    // directed write / read path
    run_txn(2'b00, 8'hA5);
    run_txn(2'b01, 8'h3C);
    chk("ram_a5", 32'(s_mem[8'hA5]), 32'h3C);
    run_txn(2'b10, 8'hA5);
    run_txn(2'b11, 8'h00);
    chk("rd_3c", 32'(rd_data), 32'h3C);

    // start held high: frames every 12 cycles, one deselected cycle between
    d5 = 8'($urandom);
    @(negedge clk);
    start = 1'b1; cmd = 2'b00; wr_data = d5;
    bad = 0; dones = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (SS_n !== !(((k - 1) % 12) < 11)) bad++;
      if (done === 1'b1) begin
        dones++;
        if (k % 12 != 0) bad++;
      end
    end
    start = 1'b0;
    repeat (15) @(negedge clk);
    chk("b2b_shape", bad, 0);
    chk("b2b_dones", dones, 3);
    chk("b2b_idle",  32'(busy), 0);
    ref_addr = d5;

    // MISO stuck high, then a write must not touch rd_data/rd_valid
    miso_stuck = 1'b1;
    run_txn(2'b11, 8'h00);
    chk("stuck_ff", 32'(rd_data), 32'hFF);
    miso_stuck = 1'b0;
    run_txn(2'b01, 8'h77);
    chk("stuck_hold", 32'(rd_data), 32'hFF);

    // random traffic
    repeat (40) run_txn(2'($urandom_range(0, 3)), 8'($urandom));

    bad = 0;
    for (int a = 0; a < 256; a++) if (s_mem[a] !== ref_mem[a]) bad++;
    chk("ram_all", bad, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
